fetch_line_buffer: RTL and testbench

Single-line instruction fetch buffer that sits directly downstream of the instruction MMU. It consumes the paged fetch address and serves fetch requests from an internal line of BURST_LEN words. On a miss it refills the whole line with one Wishbone burst read, asserting the 8-beat burst hint. Its bus port attaches to the instruction Wishbone master port.

---
 rtl/fetch_line_buffer.sv | 173 +++++++++++++++++
 tb/tb_fetch_line_buffer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_line_buffer.sv
// Single-line instruction fetch buffer behind the instruction MMU.
// Misses refill the whole line with one Wishbone burst read.
module fetch_line_buffer #(
   parameter int unsigned ADDR_W    = 24,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned BURST_LEN = 8,
   parameter int unsigned LOG_BL    = 3
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              o_ack,
   output logic [DATA_W-1:0] o_data,
   output logic              o_err,
   input  logic              i_flush,
   output logic              wb_cyc,
   output logic              wb_stb,
   output logic              wb_we,
   output logic [ADDR_W-1:0] wb_adr,
   input  logic [DATA_W-1:0] wb_i_dat,
   input  logic              wb_ack,
   input  logic              wb_err,
   output logic              wb_8_burst
);

   localparam int unsigned TAG_W = ADDR_W - LOG_BL;

   typedef enum logic [1:0] {StIdle, StBurst, StResp} state_e;

   state_e              state_q, state_d;
   logic                valid_q, valid_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [LOG_BL-1:0]   idx_q, idx_d;
   logic [LOG_BL-1:0]   beat_q, beat_d;
   logic                flush_pend_q, flush_pend_d;
   logic                drop_q, drop_d;
   logic                ack_q, ack_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                cyc_q, cyc_d;
   logic                stb_q, stb_d;
   logic [ADDR_W-1:0]   adr_q, adr_d;
   logic [DATA_W-1:0]   line_q [BURST_LEN];
   logic                line_we;

   logic [TAG_W-1:0]    req_tag;
   logic [LOG_BL-1:0]   req_idx;
   logic                hit;
   logic                last_beat;

   assign req_tag   = i_addr[ADDR_W-1:LOG_BL];
   assign req_idx   = i_addr[LOG_BL-1:0];
   assign hit       = i_req & valid_q & (req_tag == tag_q) & ~i_flush;
   assign last_beat = (beat_q == LOG_BL'(BURST_LEN - 1));

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      tag_d        = tag_q;
      idx_d        = idx_q;
      beat_d       = beat_q;
      flush_pend_d = flush_pend_q;
      drop_d       = drop_q;
      ack_d        = 1'b0;
      err_d        = 1'b0;
      data_d       = data_q;
      cyc_d        = cyc_q;
      stb_d        = stb_q;
      adr_d        = adr_q;
      line_we      = 1'b0;
      case (state_q)
         StIdle: begin
            flush_pend_d = 1'b0;
            drop_d       = 1'b0;
            if (i_flush) valid_d = 1'b0;
            // The request is still held while its own ack/err is visible; don't serve it twice.
            if (i_req && !ack_q && !err_q) begin
               if (hit) begin
                  ack_d  = 1'b1;
                  data_d = line_q[req_idx];
               end else begin
                  state_d = StBurst;
                  tag_d   = req_tag;
                  idx_d   = req_idx;
                  valid_d = 1'b0;
                  cyc_d   = 1'b1;
                  stb_d   = 1'b1;
                  adr_d   = {req_tag, {LOG_BL{1'b0}}};
                  beat_d  = '0;
               end
            end
         end
         StBurst: begin
            if (i_flush) flush_pend_d = 1'b1;
            if (!i_req) drop_d = 1'b1;
            if (wb_err) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               valid_d = 1'b0;
               err_d   = 1'b1;
               state_d = StIdle;
            end else if (wb_ack) begin
               line_we                = 1'b1;
               beat_d                 = beat_q + 1'b1;
               adr_d[LOG_BL-1:0]      = adr_q[LOG_BL-1:0] + 1'b1;
               if (last_beat) begin
                  cyc_d   = 1'b0;
                  stb_d   = 1'b0;
                  valid_d = ~(flush_pend_q | i_flush);
                  state_d = StResp;
               end
            end
         end
         StResp: begin
            if (!drop_q) begin
               ack_d  = 1'b1;
               data_d = line_q[idx_q];
            end
            if (i_flush) valid_d = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= StIdle;
         valid_q      <= 1'b0;
         tag_q        <= '0;
         idx_q        <= '0;
         beat_q       <= '0;
         flush_pend_q <= 1'b0;
         drop_q       <= 1'b0;
         ack_q        <= 1'b0;
         err_q        <= 1'b0;
         data_q       <= '0;
         cyc_q        <= 1'b0;
         stb_q        <= 1'b0;
         adr_q        <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         tag_q        <= tag_d;
         idx_q        <= idx_d;
         beat_q       <= beat_d;
         flush_pend_q <= flush_pend_d;
         drop_q       <= drop_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         data_q       <= data_d;
         cyc_q        <= cyc_d;
         stb_q        <= stb_d;
         adr_q        <= adr_d;
      end
   end

   // Line storage needs no reset; valid_q guards its contents.
   always_ff @(posedge i_clk) begin
      if (line_we && !i_rst) line_q[beat_q] <= wb_i_dat;
   end

   assign o_ack      = ack_q;
   assign o_err      = err_q;
   assign o_data     = data_q;
   assign wb_cyc     = cyc_q;
   assign wb_stb     = stb_q;
   assign wb_we      = 1'b0;
   assign wb_adr     = adr_q;
   assign wb_8_burst = (BURST_LEN == 8) ? cyc_q : 1'b0;

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Scoreboard bench for fetch_line_buffer: a line-level reference model predicts each
// response; a negedge process plays the Wishbone slave and checks what the DUT presents.
module tb_fetch_line_buffer;

   localparam int AW = 24;
   localparam int DW = 16;
   localparam int BL = 8;

   logic          clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic          o_ack, o_err;
   logic [DW-1:0] o_data;
   logic          i_flush = 1'b0;
   logic          wb_cyc, wb_stb, wb_we, wb_8_burst;
   logic [AW-1:0] wb_adr;
   logic [DW-1:0] wb_i_dat = '0;
   logic          wb_ack = 1'b0;
   logic          wb_err = 1'b0;

   always #5 clk = ~clk;

   fetch_line_buffer dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .o_ack      (o_ack),
      .o_data     (o_data),
      .o_err      (o_err),
      .i_flush    (i_flush),
      .wb_cyc     (wb_cyc),
      .wb_stb     (wb_stb),
      .wb_we      (wb_we),
      .wb_adr     (wb_adr),
      .wb_i_dat   (wb_i_dat),
      .wb_ack     (wb_ack),
      .wb_err     (wb_err),
      .wb_8_burst (wb_8_burst)
   );

   typedef struct {
      bit          is_err;
      logic [15:0] data;
      int          lat;
      int          bursts;
   } exp_t;

   exp_t sb[$];

   int n_vec = 0;
   int n_miss = 0;
   int timeouts = 0;

   // Knobs set by the driver, consumed by the slave process.
   int waits = 0;
   int err_beat = -1;
   int flush_beat = -1;
   int rst_beat = -1;
   bit rst_req = 1'b1;
   bit flush_req = 1'b0;
   bit done = 1'b0;
   bit checked = 1'b0;

   // Reference model: one line, valid + tag.
   bit          m_valid = 1'b0;
   logic [20:0] m_tag = '0;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void push_exp(input bit is_err, input logic [15:0] data, input int lat,
                                    input int bursts);
      exp_t e;
      e.is_err = is_err;
      e.data   = data;
      e.lat    = lat;
      e.bursts = bursts;
      sb.push_back(e);
   endfunction

   // Slave + monitor: the only process that drives i_rst, i_flush and the Wishbone inputs.
   initial begin
      int          cycle, start, bursts, bursts0, beat, wcnt;
      bit          in_burst, req_prev, rst_prev;
      logic [AW-1:0] base, exp_adr;
      logic [2:0]  bl;
      exp_t        e;
      cycle = 0; start = 0; bursts = 0; bursts0 = 0; beat = 0; wcnt = 0;
      in_burst = 0; req_prev = 0; rst_prev = 0; base = '0;
      forever begin
         @(negedge clk);
         cycle++;
         if (rst_prev) begin
            chk("rst_cyc", wb_cyc, 0);
            chk("rst_stb", wb_stb, 0);
            chk("rst_adr", wb_adr, 0);
            chk("rst_ack", o_ack, 0);
            chk("rst_err", o_err, 0);
            chk("rst_data", o_data, 0);
         end
         wb_ack  = 1'b0;
         wb_err  = 1'b0;
         i_flush = flush_req;
         i_rst   = rst_req;
         if (i_req && !req_prev) begin
            start   = cycle;
            bursts0 = bursts;
         end
         req_prev = i_req;
         if (o_ack || o_err) begin
            chk("ack_err_excl", {31'b0, o_ack & o_err}, 0);
            chk("cyc_on_resp", wb_cyc, 0);
            if (sb.size() == 0) begin
               chk("unexpected_resp", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("resp_is_err", o_err, e.is_err);
               if (!e.is_err) chk("resp_data", o_data, e.data);
               chk("resp_latency", cycle - start, e.lat);
               chk("resp_bursts", bursts - bursts0, e.bursts);
            end
         end
         if (wb_cyc && wb_stb) begin
            chk("burst_hint", wb_8_burst, 1);
            chk("we_low", wb_we, 0);
            if (!in_burst) begin
               in_burst = 1;
               beat     = 0;
               wcnt     = 0;
               bursts++;
               base     = {i_addr[AW-1:3], 3'b000};
            end
            if (wcnt < waits) begin
               wcnt++;
            end else begin
               bl      = beat[2:0];
               exp_adr = {base[AW-1:3], bl};
               chk("beat_adr", wb_adr, exp_adr);
               wcnt     = 0;
               wb_i_dat = wb_adr[15:0];
               if (beat == err_beat) begin
                  wb_err = 1'b1;
               end else begin
                  wb_ack = 1'b1;
                  if (beat == rst_beat) i_rst = 1'b1;
                  if (beat == flush_beat) i_flush = 1'b1;
               end
               beat++;
            end
         end else begin
            in_burst = 0;
         end
         if (done && !checked) begin
            chk("scoreboard_empty", sb.size(), 0);
            chk("timeouts", timeouts, 0);
            checked = 1'b1;
         end
         rst_prev = i_rst;
      end
   end

   task automatic do_req(input logic [AW-1:0] a, input int w, input int eb, input int fb,
                         input int rb);
      logic [20:0] t;
      bit          got;
      t = a[AW-1:3];
      @(posedge clk); #1;
      waits = w; err_beat = eb; flush_beat = fb; rst_beat = rb;
      if (m_valid && t == m_tag) begin
         push_exp(1'b0, a[15:0], 1, 0);
      end else if (eb >= 0) begin
         push_exp(1'b1, '0, (eb + 1) * (w + 1) + 1, 1);
         m_valid = 1'b0;
      end else if (rb >= 0) begin
         m_valid = 1'b0;
      end else begin
         push_exp(1'b0, a[15:0], 2 + BL * (w + 1), 1);
         m_valid = (fb < 0);
         m_tag   = t;
      end
      i_addr = a;
      i_req  = 1'b1;
      got = 0;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk); #1;
         if (o_ack || o_err || i_rst) begin
            got = 1;
            break;
         end
      end
      if (!got) timeouts++;
      i_req = 1'b0;
      err_beat = -1; flush_beat = -1; rst_beat = -1;
      repeat (3) @(posedge clk);
   endtask

   task automatic do_flush();
      @(posedge clk); #1;
      flush_req = 1'b1;
      @(posedge clk); #1;
      flush_req = 1'b0;
      m_valid = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      logic [AW-1:0] a;
      logic [20:0]   t;
      int            r;
      repeat (3) @(posedge clk);
      #1 rst_req = 1'b0;
      repeat (3) @(posedge clk);

      do_req(24'h000103, 0, -1, -1, -1);  // cold miss
      do_req(24'h000107, 0, -1, -1, -1);  // hits
      do_req(24'h000100, 0, -1, -1, -1);
      do_req(24'h000200, 0, 5, -1, -1);   // bus error on beat 5
      do_req(24'h000200, 0, -1, -1, -1);  // retry refills
      do_req(24'h000300, 0, -1, 3, -1);   // flush mid-burst
      do_req(24'h000301, 0, -1, -1, -1);  // line left invalid -> miss
      do_req(24'hFFFFFA, 2, -1, -1, -1);  // wait states + top-of-space line
      do_req(24'hFFFFFF, 0, -1, -1, -1);
      do_flush();
      do_req(24'hFFFFF8, 0, -1, -1, -1);  // flushed in idle -> miss
      do_req(24'h000400, 0, -1, -1, 4);   // reset mid-burst
      do_req(24'h000400, 0, -1, -1, -1);  // same line misses again
      do_req(24'h000406, 1, -1, 7, -1);   // flush coincident with last ack

      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 3);
         case (r)
            0: t = 21'h000020;
            1: t = 21'h000021;
            2: t = 21'h1FFFFF;
            default: t = 21'($urandom);
         endcase
         a = {t, 3'($urandom)};
         r = $urandom_range(0, 9);
         case (r)
            0: do_req(a, $urandom_range(0, 2), $urandom_range(0, BL - 1), -1, -1);
            1: do_req(a, $urandom_range(0, 2), -1, $urandom_range(0, BL - 1), -1);
            2: do_req(a, $urandom_range(0, 2), -1, -1, $urandom_range(0, BL - 1));
            3: begin
               do_flush();
               do_req(a, $urandom_range(0, 2), -1, -1, -1);
            end
            default: do_req(a, $urandom_range(0, 2), -1, -1, -1);
         endcase
      end

      repeat (5) @(posedge clk);
      done = 1'b1;
      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
